// File: rtl/m_axis_rc_skid.sv
// Two-entry registered skid buffer (main M + skid S) on the 512-bit RC AXI-Stream path.
// tready_h is a flop. Optional completion statistics are enabled by defining M_AXIS_RC_SKID_STATS_EN.
module m_axis_rc_skid #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic [DATA_WIDTH-1:0] m_axis_rc_tdata_h,
  input  logic [KEEP_WIDTH-1:0] m_axis_rc_tkeep_h,
  input  logic                  m_axis_rc_tlast_h,
  input  logic [84:0]           m_axis_rc_tuser_h,
  input  logic                  m_axis_rc_tvalid_h,
  output logic [3:0]            m_axis_rc_tready_h,
  output logic [DATA_WIDTH-1:0] m_axis_rc_tdata_a,
  output logic [KEEP_WIDTH-1:0] m_axis_rc_tkeep_a,
  output logic                  m_axis_rc_tlast_a,
  output logic [84:0]           m_axis_rc_tuser_a,
  output logic                  m_axis_rc_tvalid_a,
  input  logic [3:0]            m_axis_rc_tready_a,
  output logic [31:0]           rc_tlp_count,
  output logic [15:0]           rc_discontinue_count,
  output logic [1:0]            rc_skid_state
);
  localparam int USER_WIDTH = 85;
  localparam int BEAT_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;

  // Valid/ready: a beat moves on an edge where valid and ready are both high; once valid is
  // raised it holds the same beat until that transfer. Only tready_a[0] is honoured.
  // State bits are the entry valid flags: bit 0 = M valid, bit 1 = S valid.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } skid_state_e;

  skid_state_e           state_q, state_d;
  logic                  ready_q;
  logic                  in_accept, out_accept;
  logic                  load_m_in, load_m_skid, load_s;
  logic [BEAT_WIDTH-1:0] in_beat, m_beat, s_beat;
  logic                  unused_ready_hi;

  assign unused_ready_hi = ^m_axis_rc_tready_a[3:1];

  assign in_beat    = {m_axis_rc_tdata_h, m_axis_rc_tkeep_h, m_axis_rc_tlast_h, m_axis_rc_tuser_h};
  assign in_accept  = m_axis_rc_tvalid_h & ready_q;
  assign out_accept = state_q[0] & m_axis_rc_tready_a[0];

  always_comb begin
    state_d     = state_q;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_accept) begin
          state_d   = ONE;
          load_m_in = 1'b1;
        end
      end
      ONE: begin
        case ({in_accept, out_accept})
          2'b11:   load_m_in = 1'b1;
          2'b10: begin
            state_d = FULL;
            load_s  = 1'b1;
          end
          2'b01:   state_d = EMPTY;
          default: state_d = ONE;
        endcase
      end
      FULL: begin
        // ready_q is low here, so only the drain side can move
        if (out_accept) begin
          state_d     = ONE;
          load_m_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ~state_d[1];
    end
  end

  // Payload registers carry no reset; the valid flags above qualify them.
  always_ff @(posedge user_clk) begin
    if (load_m_in) begin
      m_beat <= in_beat;
    end else if (load_m_skid) begin
      m_beat <= s_beat;
    end
    if (load_s) begin
      s_beat <= in_beat;
    end
  end

  assign {m_axis_rc_tdata_a, m_axis_rc_tkeep_a, m_axis_rc_tlast_a, m_axis_rc_tuser_a} = m_beat;
  assign m_axis_rc_tvalid_a = state_q[0];
  assign m_axis_rc_tready_h = {4{ready_q}};
  assign rc_skid_state      = state_q;

`ifdef M_AXIS_RC_SKID_STATS_EN
  logic [31:0] tlp_cnt_q;
  logic [15:0] disc_cnt_q;
  logic        tlp_done;

  assign tlp_done = out_accept & m_axis_rc_tlast_a;

  // TLP count wraps; discontinue count sticks at all-ones
  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      tlp_cnt_q  <= '0;
      disc_cnt_q <= '0;
    end else if (tlp_done) begin
      tlp_cnt_q <= tlp_cnt_q + 32'd1;
      if (m_axis_rc_tuser_a[42] && (disc_cnt_q != 16'hFFFF)) begin
        disc_cnt_q <= disc_cnt_q + 16'd1;
      end
    end
  end

  assign rc_tlp_count         = tlp_cnt_q;
  assign rc_discontinue_count = disc_cnt_q;
`else
  assign rc_tlp_count         = '0;
  assign rc_discontinue_count = '0;
`endif

endmodule

// File: tb/tb_m_axis_rc_skid.sv
// Bench for m_axis_rc_skid: a FIFO-of-depth-2 reference model scores every output beat.
// Builds with or without M_AXIS_RC_SKID_STATS_EN.
module tb_m_axis_rc_skid;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 85;
  localparam int BW = DW + KW + 1 + UW;

  // clock / reset
  logic user_clk = 1'b0;
  logic user_reset = 1'b1;
  always #5 user_clk = ~user_clk;

  logic [DW-1:0] tdata_h, tdata_a;
  logic [KW-1:0] tkeep_h, tkeep_a;
  logic          tlast_h, tlast_a;
  logic [UW-1:0] tuser_h, tuser_a;
  logic          tvalid_h, tvalid_a;
  logic [3:0]    tready_h, tready_a;
  logic [31:0]   tlp_count;
  logic [15:0]   disc_count;
  logic [1:0]    skid_state;
  logic [BW-1:0] beat_h, beat_a;

  assign beat_h = {tdata_h, tkeep_h, tlast_h, tuser_h};
  assign beat_a = {tdata_a, tkeep_a, tlast_a, tuser_a};

  m_axis_rc_skid dut (
    .user_clk             (user_clk),
    .user_reset           (user_reset),
    .m_axis_rc_tdata_h    (tdata_h),
    .m_axis_rc_tkeep_h    (tkeep_h),
    .m_axis_rc_tlast_h    (tlast_h),
    .m_axis_rc_tuser_h    (tuser_h),
    .m_axis_rc_tvalid_h   (tvalid_h),
    .m_axis_rc_tready_h   (tready_h),
    .m_axis_rc_tdata_a    (tdata_a),
    .m_axis_rc_tkeep_a    (tkeep_a),
    .m_axis_rc_tlast_a    (tlast_a),
    .m_axis_rc_tuser_a    (tuser_a),
    .m_axis_rc_tvalid_a   (tvalid_a),
    .m_axis_rc_tready_a   (tready_a),
    .rc_tlp_count         (tlp_count),
    .rc_discontinue_count (disc_count),
    .rc_skid_state        (skid_state)
  );

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];
  bit sb_en = 1'b0;
  bit ready_armed = 1'b0;
  int out_beats = 0;

  // scoreboard: the buffer is a 2-deep FIFO; valid/ready follow occupancy
  always @(negedge user_clk) begin
    logic [BW-1:0] exp_beat;
    if (sb_en && !user_reset) begin
      checks++;
      if (tready_h !== {4{tready_h[0]}}) begin
        errors++; $display("FAIL ready_bits_equal got %b want all equal", tready_h);
      end
      checks++;
      if (tvalid_a !== (exp_q.size() != 0)) begin
        errors++; $display("FAIL valid_occupancy got %b want %0d (occupancy %0d)", tvalid_a, exp_q.size() != 0, exp_q.size());
      end
      if (ready_armed) begin
        checks++;
        if (tready_h !== ((exp_q.size() < 2) ? 4'hF : 4'h0)) begin
          errors++; $display("FAIL ready_occupancy got %h occupancy %0d", tready_h, exp_q.size());
        end
      end
      if (tvalid_a === 1'b1 && tready_a[0] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL unexpected_beat got %h want none", beat_a);
        end else begin
          exp_beat = exp_q.pop_front();
          out_beats++;
          if (beat_a !== exp_beat) begin
            errors++; $display("FAIL beat_data got %h want %h", beat_a, exp_beat);
          end
        end
      end
      if (tvalid_h === 1'b1 && tready_h[0] === 1'b1) exp_q.push_back(beat_h);
    end
  end

  // driver helpers
  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < (BW + 31) / 32; i++) b = (b << 32) | BW'($urandom);
    return b;
  endfunction

  task automatic set_beat(input logic [BW-1:0] b);
    {tdata_h, tkeep_h, tlast_h, tuser_h} = b;
  endtask

  task automatic go_idle();
    @(posedge user_clk); #1;
    tvalid_h = 1'b0;
    tready_a = 4'hF;
    repeat (3) @(posedge user_clk);
    #1;
  endtask

  task automatic send_tlp(input int len, input bit disc);
    logic [BW-1:0] b;
    logic acc;
    int wait_cyc;
    for (int i = 0; i < len; i++) begin
      b = rand_beat();
      b[UW] = (i == len - 1);
      b[42] = (i == len - 1) ? disc : 1'b1;
      set_beat(b);
      tvalid_h = 1'b1;
      wait_cyc = 0;
      acc = 1'b0;
      while (!acc && wait_cyc < 50) begin
        @(negedge user_clk);
        acc = tready_h[0];
        @(posedge user_clk); #1;
        wait_cyc++;
      end
      checks++;
      if (!acc) begin
        errors++; $display("FAIL send_tlp_timeout got no accept want accept within 50 cycles");
      end
    end
    tvalid_h = 1'b0;
  endtask

  task automatic test_reset();
    sb_en = 1'b0; ready_armed = 1'b0; exp_q.delete();
    user_reset = 1'b1; tvalid_h = 1'b0; tready_a = 4'hF; set_beat('0);
    repeat (2) @(posedge user_clk);
    @(negedge user_clk);
    checks++;
    if (tvalid_a !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", tvalid_a); end
    checks++;
    if (tready_h !== 4'h0) begin errors++; $display("FAIL reset_tready got %h want 0", tready_h); end
    checks++;
    if (tlp_count !== 32'd0) begin errors++; $display("FAIL reset_tlp_count got %0d want 0", tlp_count); end
    checks++;
    if (disc_count !== 16'd0) begin errors++; $display("FAIL reset_disc_count got %0d want 0", disc_count); end
    @(posedge user_clk); #1;
    user_reset = 1'b0; sb_en = 1'b1;
    @(negedge user_clk);
    checks++;
    if (tready_h !== 4'h0) begin errors++; $display("FAIL ready_before_edge got %h want 0", tready_h); end
    @(posedge user_clk); #1;
    checks++;
    if (tready_h !== 4'hF) begin errors++; $display("FAIL ready_after_edge got %h want f", tready_h); end
    ready_armed = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] arr[4];
    for (int i = 0; i < 4; i++) begin
      arr[i] = rand_beat();
      arr[i][UW] = (i == 3);
    end
    tready_a = 4'hF;
    for (int i = 0; i <= 4; i++) begin
      @(posedge user_clk); #1;
      if (i < 4) begin set_beat(arr[i]); tvalid_h = 1'b1; end
      else tvalid_h = 1'b0;
      @(negedge user_clk);
      checks++;
      if (i == 0) begin
        if (tvalid_a !== 1'b0) begin errors++; $display("FAIL b2b_latency got %b want 0", tvalid_a); end
      end else if (tvalid_a !== 1'b1 || beat_a !== arr[i-1]) begin
        errors++; $display("FAIL b2b_beat%0d got v=%b %h want v=1 %h", i - 1, tvalid_a, beat_a, arr[i-1]);
      end
    end
  endtask

  task automatic test_stall();
    logic [BW-1:0] arr[3];
    logic [BW-1:0] got[$];
    logic acc;
    int k;
    go_idle();
    for (int i = 0; i < 3; i++) arr[i] = rand_beat();
    tready_a = 4'h0;
    k = 0; set_beat(arr[0]); tvalid_h = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge user_clk); acc = tvalid_h && tready_h[0];
      @(posedge user_clk); #1;
      if (acc) begin
        k++;
        if (k < 3) set_beat(arr[k]); else tvalid_h = 1'b0;
      end
    end
    @(negedge user_clk);
    checks++;
    if (k !== 2) begin errors++; $display("FAIL stall_taken got %0d want 2", k); end
    checks++;
    if (tready_h !== 4'h0) begin errors++; $display("FAIL stall_ready got %h want 0", tready_h); end
    checks++;
    if (skid_state !== 2'b11) begin errors++; $display("FAIL stall_state got %b want 11", skid_state); end
    checks++;
    if (beat_a !== arr[0]) begin errors++; $display("FAIL stall_head got %h want %h", beat_a, arr[0]); end
    @(posedge user_clk); #1;
    tready_a = 4'hF;
    for (int c = 0; c < 6; c++) begin
      @(negedge user_clk);
      acc = tvalid_h && tready_h[0];
      if (tvalid_a && tready_a[0]) got.push_back(beat_a);
      @(posedge user_clk); #1;
      if (acc) begin
        k++;
        if (k < 3) set_beat(arr[k]); else tvalid_h = 1'b0;
      end
    end
    checks++;
    if (got.size() != 3) begin errors++; $display("FAIL stall_drain_count got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== arr[i]) begin errors++; $display("FAIL stall_order%0d got %h want %h", i, got[i], arr[i]); end
    end
  endtask

  task automatic test_simultaneous();
    go_idle();
    for (int c = 0; c <= 100; c++) begin
      set_beat(rand_beat()); tvalid_h = 1'b1;
      @(negedge user_clk);
      if (c > 0) begin
        checks++;
        if (skid_state !== 2'b01 || tready_h !== 4'hF) begin
          errors++; $display("FAIL simul_cycle%0d got state=%b ready=%h want 01 f", c, skid_state, tready_h);
        end
      end
      @(posedge user_clk); #1;
    end
    tvalid_h = 1'b0;
  endtask

  task automatic test_async_reset();
    go_idle();
    tready_a = 4'h0;
    set_beat(rand_beat()); tvalid_h = 1'b1;
    @(posedge user_clk); #1;
    set_beat(rand_beat());
    @(posedge user_clk); #1;
    tvalid_h = 1'b0;
    @(negedge user_clk);
    checks++;
    if (skid_state !== 2'b11) begin errors++; $display("FAIL areset_prefill got %b want 11", skid_state); end
    #2;
    user_reset = 1'b1; sb_en = 1'b0; ready_armed = 1'b0; exp_q.delete();
    #1;
    checks++;
    if (tvalid_a !== 1'b0 || tready_h !== 4'h0) begin
      errors++; $display("FAIL areset_immediate got v=%b r=%h want 0 0", tvalid_a, tready_h);
    end
    repeat (2) @(posedge user_clk);
    #1;
    user_reset = 1'b0; sb_en = 1'b1; tready_a = 4'hF;
    @(posedge user_clk); #1;
    ready_armed = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge user_clk);
      checks++;
      if (tvalid_a !== 1'b0 || skid_state !== 2'b00) begin
        errors++; $display("FAIL areset_stale%0d got v=%b state=%b want 0 00", c, tvalid_a, skid_state);
      end
    end
  endtask

  task automatic test_random();
    int sent, base, cyc;
    logic acc;
    go_idle();
    sent = 0; base = out_beats; cyc = 0; acc = 1'b0;
    while (cyc < 50000 && (out_beats - base) < 10000) begin
      @(posedge user_clk); #1;
      if (acc) sent++;
      if (!tvalid_h || acc) begin
        if (sent < 10000 && $urandom_range(0, 1) == 1) begin
          set_beat(rand_beat()); tvalid_h = 1'b1;
        end else tvalid_h = 1'b0;
      end
      tready_a = {3'($urandom), 1'($urandom_range(0, 1))};
      @(negedge user_clk); #1;
      acc = tvalid_h && tready_h[0];
      cyc++;
    end
    checks++;
    if ((out_beats - base) != 10000) begin
      errors++; $display("FAIL random_count got %0d want 10000 (cycles %0d)", out_beats - base, cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL random_leftover got %0d want 0", exp_q.size()); end
    go_idle();
  endtask

  task automatic test_stats();
    int exp_tlp, exp_disc;
    bit disc;
    go_idle();
`ifdef M_AXIS_RC_SKID_STATS_EN
    user_reset = 1'b1; sb_en = 1'b0; ready_armed = 1'b0; exp_q.delete();
    @(posedge user_clk); #1;
    user_reset = 1'b0; sb_en = 1'b1;
    @(posedge user_clk); #1;
    ready_armed = 1'b1;
    exp_tlp = 0; exp_disc = 0;
    for (int t = 0; t < 5; t++) begin
      disc = (t == 1 || t == 3);
      send_tlp($urandom_range(1, 3), disc);
      exp_tlp++;
      if (disc) exp_disc++;
    end
    go_idle();
    checks++;
    if (tlp_count !== 32'(exp_tlp)) begin errors++; $display("FAIL stats_tlp got %0d want %0d", tlp_count, exp_tlp); end
    checks++;
    if (disc_count !== 16'(exp_disc)) begin errors++; $display("FAIL stats_disc got %0d want %0d", disc_count, exp_disc); end
    force dut.disc_cnt_q = 16'hFFFF;
    @(posedge user_clk); #1;
    release dut.disc_cnt_q;
    send_tlp(2, 1'b1);
    go_idle();
    checks++;
    if (disc_count !== 16'hFFFF) begin errors++; $display("FAIL stats_saturate got %h want ffff", disc_count); end
    checks++;
    if (tlp_count !== 32'(exp_tlp + 1)) begin errors++; $display("FAIL stats_tlp_after got %0d want %0d", tlp_count, exp_tlp + 1); end
`else
    exp_tlp = 0; exp_disc = 0;
    for (int t = 0; t < 3; t++) begin
      disc = (t != 1);
      send_tlp($urandom_range(1, 3), disc);
    end
    go_idle();
    checks++;
    if (tlp_count !== 32'(exp_tlp)) begin errors++; $display("FAIL nostats_tlp got %0d want 0", tlp_count); end
    checks++;
    if (disc_count !== 16'(exp_disc)) begin errors++; $display("FAIL nostats_disc got %0d want 0", disc_count); end
`endif
  endtask

  initial begin
    tvalid_h = 1'b0;
    tready_a = 4'hF;
    set_beat('0);
    test_reset();
    test_back_to_back();
    test_stall();
    test_simultaneous();
    test_async_reset();
    test_random();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
